// File: rtl/nf_sume_xbar_rr_merge_pkg.sv
// Shared constants, state encoding and round-robin helper for the egress merge stage.
package nf_sume_xbar_rr_merge_pkg;

  localparam int NUM_QUEUES = 5;
  localparam int PTR_W      = 3;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_e;

  // First requesting index at or after ptr, modulo NUM_QUEUES; returns ptr when nothing requests.
  function automatic logic [PTR_W-1:0] next_rr(input logic [NUM_QUEUES-1:0] req,
                                               input logic [PTR_W-1:0]      ptr);
    int   idx;
    logic found;
    next_rr = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_QUEUES) idx = idx - NUM_QUEUES;
      if (!found && req[idx[PTR_W-1:0]]) begin
        next_rr = idx[PTR_W-1:0];
        found   = 1'b1;
      end
    end
  endfunction

  // Index of the input after p, wrapping back to 0.
  function automatic logic [PTR_W-1:0] inc_wrap(input logic [PTR_W-1:0] p);
    inc_wrap = (p == PTR_W'(NUM_QUEUES - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/nf_sume_rr_arbiter.sv
// Combinational round-robin pick among the requesting inputs.
module nf_sume_rr_arbiter
  import nf_sume_xbar_rr_merge_pkg::*;
(
  input  logic [NUM_QUEUES-1:0] req_i,
  input  logic [PTR_W-1:0]      ptr_i,
  output logic [PTR_W-1:0]      grant_idx_o,
  output logic                  any_req_o
);

  assign grant_idx_o = next_rr(req_i, ptr_i);
  assign any_req_o   = |req_i;

endmodule

// File: rtl/nf_sume_xbar_rr_merge.sv
// Per-egress merge: packet-granular round-robin over five AXI4-Stream inputs.
// Handshake: a beat moves on an edge where tvalid and tready are both high; tvalid
// is never gated by tready, and the granted input's tready is m_axis_tready itself.
module nf_sume_xbar_rr_merge
  import nf_sume_xbar_rr_merge_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_DATA_WIDTH  = 64,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PKT_CNT_WIDTH        = 16
) (
  input  logic                                  axis_aclk,
  input  logic                                  axis_aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]        s0_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]      s0_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]       s0_axis_tuser,
  input  logic                                  s0_axis_tvalid,
  output logic                                  s0_axis_tready,
  input  logic                                  s0_axis_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]        s1_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]      s1_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]       s1_axis_tuser,
  input  logic                                  s1_axis_tvalid,
  output logic                                  s1_axis_tready,
  input  logic                                  s1_axis_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]        s2_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]      s2_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]       s2_axis_tuser,
  input  logic                                  s2_axis_tvalid,
  output logic                                  s2_axis_tready,
  input  logic                                  s2_axis_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]        s3_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]      s3_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]       s3_axis_tuser,
  input  logic                                  s3_axis_tvalid,
  output logic                                  s3_axis_tready,
  input  logic                                  s3_axis_tlast,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]        s4_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]      s4_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]       s4_axis_tuser,
  input  logic                                  s4_axis_tvalid,
  output logic                                  s4_axis_tready,
  input  logic                                  s4_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]       m_axis_tuser,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic [NUM_QUEUES*PKT_CNT_WIDTH-1:0]   pkt_cnt,
  output logic                                  dbg_state_o,
  output logic [PTR_W-1:0]                      dbg_grant_o,
  output logic [PTR_W-1:0]                      dbg_rr_ptr_o
);

  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  s_tdata [NUM_QUEUES];
  logic [KEEP_W-1:0]               s_tkeep [NUM_QUEUES];
  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_tuser [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]           s_tvalid;
  logic [NUM_QUEUES-1:0]           s_tlast;
  logic [NUM_QUEUES-1:0]           s_tready;

  assign s_tdata[0] = s0_axis_tdata;  assign s_tkeep[0] = s0_axis_tkeep;  assign s_tuser[0] = s0_axis_tuser;
  assign s_tdata[1] = s1_axis_tdata;  assign s_tkeep[1] = s1_axis_tkeep;  assign s_tuser[1] = s1_axis_tuser;
  assign s_tdata[2] = s2_axis_tdata;  assign s_tkeep[2] = s2_axis_tkeep;  assign s_tuser[2] = s2_axis_tuser;
  assign s_tdata[3] = s3_axis_tdata;  assign s_tkeep[3] = s3_axis_tkeep;  assign s_tuser[3] = s3_axis_tuser;
  assign s_tdata[4] = s4_axis_tdata;  assign s_tkeep[4] = s4_axis_tkeep;  assign s_tuser[4] = s4_axis_tuser;
  assign s_tvalid = {s4_axis_tvalid, s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
  assign s_tlast  = {s4_axis_tlast,  s3_axis_tlast,  s2_axis_tlast,  s1_axis_tlast,  s0_axis_tlast};
  assign s0_axis_tready = s_tready[0];
  assign s1_axis_tready = s_tready[1];
  assign s2_axis_tready = s_tready[2];
  assign s3_axis_tready = s_tready[3];
  assign s4_axis_tready = s_tready[4];

  state_e                   state_q;
  logic [PTR_W-1:0]         grant_q;
  logic [PTR_W-1:0]         rr_ptr_q;
  logic [PKT_CNT_WIDTH-1:0] cnt_q [NUM_QUEUES];

  logic [PTR_W-1:0] arb_idx;
  logic             arb_any;
  logic             sel_valid;
  logic             sel_last;
  logic             xfer;

  nf_sume_rr_arbiter u_arb (
    .req_i       (s_tvalid),
    .ptr_i       (rr_ptr_q),
    .grant_idx_o (arb_idx),
    .any_req_o   (arb_any)
  );

  // Route the granted input straight to the master while a packet is open; idle outputs are 0.
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tkeep = '0;
    m_axis_tuser = '0;
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    s_tready     = '0;
    if (state_q == PKT) begin
      for (int k = 0; k < NUM_QUEUES; k++) begin
        if (grant_q == PTR_W'(k)) begin
          m_axis_tdata = s_tdata[k];
          m_axis_tkeep = s_tkeep[k];
          m_axis_tuser = s_tuser[k];
          sel_valid    = s_tvalid[k];
          sel_last     = s_tlast[k];
          s_tready[k]  = m_axis_tready;
        end
      end
    end
  end

  assign m_axis_tvalid = sel_valid;
  assign m_axis_tlast  = sel_last;
  assign xfer          = (state_q == PKT) && sel_valid && m_axis_tready;

  // Arbitrate in IDLE, hold the grant until the tlast beat moves, then count it and advance rr_ptr.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      for (int k = 0; k < NUM_QUEUES; k++) cnt_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_idx;
            state_q <= PKT;
          end
        end
        PKT: begin
          if (xfer && sel_last) begin
            cnt_q[grant_q] <= cnt_q[grant_q] + PKT_CNT_WIDTH'(1);
            rr_ptr_q       <= inc_wrap(grant_q);
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cnt
    assign pkt_cnt[g*PKT_CNT_WIDTH +: PKT_CNT_WIDTH] = cnt_q[g];
  end

  assign dbg_state_o  = state_q;
  assign dbg_grant_o  = grant_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_nf_sume_xbar_rr_merge.sv
// Directed bench for the round-robin merge: per-input beat drivers, output scoreboard, directed checks.
module tb_nf_sume_xbar_rr_merge;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0]  s_tdata [5];
  logic [7:0]   s_tkeep [5];
  logic [127:0] s_tuser [5];
  logic [4:0]   s_tvalid;
  logic [4:0]   s_tlast;
  wire  [4:0]   s_tready;
  wire  [63:0]  m_tdata;
  wire  [7:0]   m_tkeep;
  wire  [127:0] m_tuser;
  wire          m_tvalid;
  wire          m_tlast;
  logic         m_tready;
  wire  [5*CW-1:0] pkt_cnt;
  wire          dbg_state;
  wire  [2:0]   dbg_grant;
  wire  [2:0]   dbg_rr;

  nf_sume_xbar_rr_merge #(.PKT_CNT_WIDTH(CW)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n),
    .s0_axis_tdata(s_tdata[0]), .s0_axis_tkeep(s_tkeep[0]), .s0_axis_tuser(s_tuser[0]),
    .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tready(s_tready[0]), .s0_axis_tlast(s_tlast[0]),
    .s1_axis_tdata(s_tdata[1]), .s1_axis_tkeep(s_tkeep[1]), .s1_axis_tuser(s_tuser[1]),
    .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tready(s_tready[1]), .s1_axis_tlast(s_tlast[1]),
    .s2_axis_tdata(s_tdata[2]), .s2_axis_tkeep(s_tkeep[2]), .s2_axis_tuser(s_tuser[2]),
    .s2_axis_tvalid(s_tvalid[2]), .s2_axis_tready(s_tready[2]), .s2_axis_tlast(s_tlast[2]),
    .s3_axis_tdata(s_tdata[3]), .s3_axis_tkeep(s_tkeep[3]), .s3_axis_tuser(s_tuser[3]),
    .s3_axis_tvalid(s_tvalid[3]), .s3_axis_tready(s_tready[3]), .s3_axis_tlast(s_tlast[3]),
    .s4_axis_tdata(s_tdata[4]), .s4_axis_tkeep(s_tkeep[4]), .s4_axis_tuser(s_tuser[4]),
    .s4_axis_tvalid(s_tvalid[4]), .s4_axis_tready(s_tready[4]), .s4_axis_tlast(s_tlast[4]),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .pkt_cnt(pkt_cnt), .dbg_state_o(dbg_state), .dbg_grant_o(dbg_grant), .dbg_rr_ptr_o(dbg_rr)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard entry: {tuser[31:0], tkeep, tlast, tdata}
  logic [104:0] exp_q[$];

  // Per-input driver state: entry = {gap_before[3:0], last, data}
  logic [68:0] pk_mem [5][24];
  int          pk_len [5];
  int          pk_pos [5];
  int          gap_cnt[5];
  logic [4:0]  hs;

  function automatic logic [104:0] beat_word(input logic [63:0] d, input logic last);
    logic [127:0] u;
    u = {d, ~d};
    return {u[31:0], d[7:0] ^ 8'h5A, last, d};
  endfunction

  task automatic present(input int q);
    logic [63:0] d;
    if (gap_cnt[q] == 0 && pk_pos[q] < pk_len[q]) begin
      d = pk_mem[q][pk_pos[q]][63:0];
      s_tvalid[q] = 1'b1;
      s_tdata[q]  = d;
      s_tkeep[q]  = d[7:0] ^ 8'h5A;
      s_tuser[q]  = {d, ~d};
      s_tlast[q]  = pk_mem[q][pk_pos[q]][64];
    end else begin
      s_tvalid[q] = 1'b0;
      s_tdata[q]  = '0;
      s_tkeep[q]  = '0;
      s_tuser[q]  = '0;
      s_tlast[q]  = 1'b0;
    end
  endtask

  task automatic load(input int q, input int n, input logic [63:0] base, input bit all_last,
                      input int gap_at, input int gap_len);
    logic [3:0] g;
    logic       l;
    for (int i = 0; i < n; i++) begin
      g = (i == gap_at) ? 4'(gap_len) : 4'd0;
      l = all_last || (i == n - 1);
      pk_mem[q][i] = {g, l, base + 64'(i)};
    end
    pk_len[q]  = n;
    pk_pos[q]  = 0;
    gap_cnt[q] = (gap_at == 0) ? gap_len : 0;
    present(q);
  endtask

  task automatic expect_pkt(input int n, input logic [63:0] base, input bit all_last);
    for (int i = 0; i < n; i++) exp_q.push_back(beat_word(base + 64'(i), all_last || (i == n - 1)));
  endtask

  task automatic clear_drivers();
    for (int q = 0; q < 5; q++) begin
      pk_len[q] = 0; pk_pos[q] = 0; gap_cnt[q] = 0;
      present(q);
    end
  endtask

  // One clock: observe at negedge (scoreboard + handshakes), then advance drivers after posedge.
  task automatic cyc();
    logic [104:0] got;
    logic [104:0] exp;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      got = {m_tuser[31:0], m_tkeep, m_tlast, m_tdata};
      if (exp_q.size() == 0) check("beat_unexpected_depth", 128'(exp_q.size()), 128'd1);
      else begin
        exp = exp_q.pop_front();
        check("m_beat", 128'(got), 128'(exp));
      end
    end
    @(posedge clk); #1;
    for (int q = 0; q < 5; q++) begin
      if (hs[q]) begin
        pk_pos[q]++;
        gap_cnt[q] = (pk_pos[q] < pk_len[q]) ? int'(pk_mem[q][pk_pos[q]][68:65]) : 0;
      end else if (gap_cnt[q] > 0) begin
        gap_cnt[q]--;
      end
      present(q);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_drivers();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  logic [6:0] pat;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    m_tready = 1'b1;
    clear_drivers();
    @(posedge clk); #1;

    // Reset: a valid input must not leak through
    load(0, 1, 64'hFF, 1'b1, -1, 0);
    #1;
    check("rst_m_tvalid", 128'(m_tvalid), 128'd0);
    check("rst_tready",   128'(s_tready), 128'd0);
    check("rst_pkt_cnt",  128'(pkt_cnt),  128'd0);
    check("rst_m_tdata",  128'(m_tdata),  128'd0);
    check("rst_m_tlast",  128'(m_tlast),  128'd0);
    check("rst_m_tuser",  128'(m_tuser),  128'd0);
    check("rst_state",    128'(dbg_state), 128'd0);
    check("rst_rr",       128'(dbg_rr),   128'd0);
    clear_drivers();
    rst_n = 1'b1;
    cyc();

    // Test 1: only s2, 3 beats A1..A3
    load(2, 3, 64'hA1, 1'b0, -1, 0);
    expect_pkt(3, 64'hA1, 1'b0);
    #1;
    check("t1_arb_cycle_valid", 128'(m_tvalid), 128'd0);
    check("t1_arb_cycle_tready", 128'(s_tready), 128'd0);
    cyc(); #1;
    check("t1_first_valid", 128'(m_tvalid), 128'd1);
    check("t1_tready",      128'(s_tready), 128'b00100);
    check("t1_grant",       128'(dbg_grant), 128'd2);
    repeat (3) cyc();
    #1;
    check("t1_state", 128'(dbg_state), 128'd0);
    check("t1_rr",    128'(dbg_rr), 128'd3);
    check("t1_cnt",   128'(pkt_cnt), 128'h00100);
    check("t1_drained", 128'(exp_q.size()), 128'd0);

    // Test 2: s0, s1, s4 requesting together from reset
    do_reset();
    load(0, 2, 64'h10, 1'b0, -1, 0);
    load(1, 2, 64'h20, 1'b0, -1, 0);
    load(4, 2, 64'h40, 1'b0, -1, 0);
    expect_pkt(2, 64'h10, 1'b0);
    expect_pkt(2, 64'h20, 1'b0);
    expect_pkt(2, 64'h40, 1'b0);
    #1;
    check("t2_arb_valid", 128'(m_tvalid), 128'd0);
    cyc(); #1;
    check("t2_grant0", 128'(dbg_grant), 128'd0);
    check("t2_tready0", 128'(s_tready), 128'b00001);
    cyc(); cyc(); #1;
    check("t2_gap1_valid", 128'(m_tvalid), 128'd0);
    check("t2_gap1_rr", 128'(dbg_rr), 128'd1);
    cyc(); #1;
    check("t2_grant1", 128'(dbg_grant), 128'd1);
    cyc(); cyc(); #1;
    check("t2_gap2_valid", 128'(m_tvalid), 128'd0);
    check("t2_gap2_rr", 128'(dbg_rr), 128'd2);
    cyc(); #1;
    check("t2_grant4", 128'(dbg_grant), 128'd4);
    cyc(); cyc(); #1;
    check("t2_cnt", 128'(pkt_cnt), 128'h10011);
    check("t2_rr",  128'(dbg_rr), 128'd0);
    check("t2_drained", 128'(exp_q.size()), 128'd0);

    // Test 3: s3, 4 beats under tready pattern 1,0,0,1,1,0,1
    load(3, 4, 64'h30, 1'b0, -1, 0);
    expect_pkt(4, 64'h30, 1'b0);
    cyc();
    pat = 7'b1011001;
    for (int i = 0; i < 7; i++) begin
      m_tready = pat[i];
      #1;
      check("t3_tready_mirror", 128'(s_tready), pat[i] ? 128'b01000 : 128'd0);
      check("t3_valid", 128'(m_tvalid), 128'd1);
      cyc();
    end
    m_tready = 1'b1;
    #1;
    check("t3_state", 128'(dbg_state), 128'd0);
    check("t3_cnt",   128'(pkt_cnt), 128'h11011);
    check("t3_rr",    128'(dbg_rr), 128'd4);
    check("t3_drained", 128'(exp_q.size()), 128'd0);

    // Test 4: s1 drops tvalid for 3 cycles mid-packet while s0 waits
    load(1, 3, 64'h50, 1'b0, 1, 3);
    expect_pkt(3, 64'h50, 1'b0);
    expect_pkt(2, 64'h60, 1'b0);
    cyc(); #1;
    check("t4_grant1", 128'(dbg_grant), 128'd1);
    load(0, 2, 64'h60, 1'b0, -1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      check("t4_gap_valid", 128'(m_tvalid), 128'd0);
      check("t4_gap_grant", 128'(dbg_grant), 128'd1);
      check("t4_gap_tready", 128'(s_tready), 128'b00010);
      check("t4_gap_state", 128'(dbg_state), 128'd1);
    end
    cyc(); #1;
    check("t4_resume_valid", 128'(m_tvalid), 128'd1);
    check("t4_resume_data", 128'(m_tdata), 128'h51);
    cyc(); cyc(); #1;
    check("t4_idle", 128'(dbg_state), 128'd0);
    check("t4_rr", 128'(dbg_rr), 128'd2);
    cyc(); #1;
    check("t4_grant0", 128'(dbg_grant), 128'd0);
    cyc(); cyc(); #1;
    check("t4_cnt", 128'(pkt_cnt), 128'h11022);
    check("t4_drained", 128'(exp_q.size()), 128'd0);

    // Test 5: reset on the 2nd beat of a 5-beat s4 packet
    load(4, 5, 64'h70, 1'b0, -1, 0);
    exp_q.push_back(beat_word(64'h70, 1'b0));
    cyc(); cyc(); #1;
    check("t5_beat2_valid", 128'(m_tvalid), 128'd1);
    check("t5_beat2_data", 128'(m_tdata), 128'h71);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid",  128'(m_tvalid), 128'd0);
    check("t5_rst_tready", 128'(s_tready), 128'd0);
    check("t5_rst_cnt",    128'(pkt_cnt), 128'd0);
    check("t5_rst_state",  128'(dbg_state), 128'd0);
    check("t5_rst_data",   128'(m_tdata), 128'd0);
    clear_drivers();
    cyc(); cyc();
    rst_n = 1'b1;
    load(4, 5, 64'h80, 1'b0, -1, 0);
    expect_pkt(5, 64'h80, 1'b0);
    repeat (6) cyc();
    #1;
    check("t5_cnt",   128'(pkt_cnt), 128'h10000);
    check("t5_state", 128'(dbg_state), 128'd0);
    check("t5_rr",    128'(dbg_rr), 128'd0);
    check("t5_drained", 128'(exp_q.size()), 128'd0);

    // Test 6: 17 single-beat packets on s0 wrap a 4-bit counter to 1
    do_reset();
    load(0, 17, 64'h90, 1'b1, -1, 0);
    expect_pkt(17, 64'h90, 1'b1);
    repeat (40) cyc();
    #1;
    check("t6_sent", 128'(pk_pos[0]), 128'd17);
    check("t6_cnt_wrap", 128'(pkt_cnt), 128'h00001);
    check("t6_rr", 128'(dbg_rr), 128'd1);
    check("t6_drained", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nf_sume_xbar_rr_merge.md
Name: nf_sume_xbar_rr_merge

Overview:
- Per-egress merge stage of the crossbar: takes NUM_QUEUES AXI4-Stream slave inputs (one per demuxed ingress) and produces one master stream.
- Packet-granular round-robin arbitration: a grant is held from the first beat to tlast, so packets are never interleaved.
- Sits between the ingress demux stages and the egress port.
- Keeps a per-input forwarded-packet counter for debug and verification.

Parameters:
- C_M_AXIS_DATA_WIDTH, 64, master tdata width (tkeep = width/8).
- C_S_AXIS_DATA_WIDTH, 64, slave tdata width; must equal C_M_AXIS_DATA_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; must equal C_M_AXIS_TUSER_WIDTH.
- NUM_QUEUES, 5, number of slave inputs; fixed at 5 for the port list.
- PKT_CNT_WIDTH, 16, width of each per-input packet counter.

Ports:
- axis_aclk  in  1  single clock.
- axis_aresetn  in  1  asynchronous active-low reset.
- sN_axis_tdata  in  C_S_AXIS_DATA_WIDTH  slave N data (N = 0..4).
- sN_axis_tkeep  in  C_S_AXIS_DATA_WIDTH/8  slave N byte enables.
- sN_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  slave N metadata.
- sN_axis_tvalid  in  1  slave N valid.
- sN_axis_tready  out  1  slave N ready.
- sN_axis_tlast  in  1  slave N end of packet.
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  merged data.
- m_axis_tkeep  out  C_M_AXIS_DATA_WIDTH/8  merged byte enables.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  merged metadata, passed through unmodified.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  merged end of packet.
- pkt_cnt  out  NUM_QUEUES*PKT_CNT_WIDTH  packed per-input forwarded-packet counts; input i occupies slice [i*W +: W].

Behaviour:
- Reset (axis_aresetn=0, asynchronous) forces:
  - state=IDLE, grant=0, rr_ptr=0, all pkt_cnt=0.
  - All sN_axis_tready=0, m_axis_tvalid=0.
  - m_axis_tdata, tkeep, tuser and tlast driven 0.
- State machine with two states, IDLE and PKT.
- IDLE:
  - Outputs m_axis_tvalid=0 and all sN tready=0.
  - If any sN_axis_tvalid=1, select the first valid input searching rr_ptr, rr_ptr+1, ... modulo NUM_QUEUES.
  - Register the winner as grant and move to PKT on the next edge.
  - If no input is valid, stay in IDLE.
- PKT:
  - Combinational path from sG to m: m_axis_t* = sG_axis_t*, and sG_axis_tready = m_axis_tready. All other sN tready=0.
  - A beat transfers when sG tvalid and m_axis_tready are both 1.
  - On a transfer with tlast=1: pkt_cnt[G] increments, rr_ptr = (G+1) mod NUM_QUEUES, return to IDLE.
- Latency:
  - 0 cycles per beat inside a packet.
  - Exactly 1 idle output cycle between packets (the arbitration cycle).
- tvalid dropping mid-packet on the granted input: the grant is held and m_axis_tvalid follows the input. No re-arbitration before tlast.
- Backpressure: m_axis_tready=0 stalls the granted input only; no data is lost or duplicated.
- Single-beat packet (tvalid and tlast on the first beat): counted, returns to IDLE on the same edge.
- Simultaneous requests: the winner is the nearest index at or after rr_ptr; inputs not chosen wait with tready=0.
- Counter wrap: pkt_cnt wraps modulo 2^PKT_CNT_WIDTH, with no saturation.
- Reset asserted mid-packet: the packet is truncated at the output, state and counters clear immediately, and the upstream must resend.

Decomposition:
- Shared package holds:
  - localparam NUM_QUEUES=5.
  - State encoding: IDLE=1'b0, PKT=1'b1.
  - Function next_rr(req, ptr), returning the round-robin winner index.
- One natural sub-module: nf_sume_rr_arbiter.
  - Inputs: req[NUM_QUEUES-1:0], ptr.
  - Outputs: grant_idx, any_req.
  - Purely combinational; the top level owns state, rr_ptr and the counters.

Test Plan:
- Only s2 sends a 3-beat packet with tdata 0xA1, 0xA2, 0xA3 -> m sees the 3 beats in order starting 1 cycle after s2 tvalid, tlast on 0xA3; pkt_cnt[2]=1, rr_ptr=3.
- s0, s1 and s4 each hold one 2-beat packet, requested in the same cycle from reset -> output order s0, s1, s4; exactly 1 idle cycle between packets; counts 1, 1, 0, 0, 1.
- s3 sends a 4-beat packet while m_axis_tready toggles 1,0,0,1,1,0,1 -> the 4 beats are delivered exactly once each and in order; s3_axis_tready mirrors m_axis_tready; no other input gets tready.
- s1 drops tvalid for 3 cycles mid-packet while s0 is valid -> the grant stays on s1; s0 is served only after s1's tlast.
- Reset asserted on the 2nd beat of a 5-beat s4 packet -> all tready and m_axis_tvalid go 0 immediately; pkt_cnt=0; after reset release a new s4 packet flows from beat 1.
- With PKT_CNT_WIDTH=4, send 17 single-beat packets on s0 -> pkt_cnt[0]=1 (wraps at 16).
